// File: rtl/bsram_pkg.sv
// rtl/bsram_pkg.sv - shared constants and lane-merge helper for the BSRAM models
package bsram_pkg;

    localparam logic READ_BYPASS   = 1'b0;
    localparam logic READ_PIPELINE = 1'b1;

    localparam logic [1:0] WR_NORMAL  = 2'b00;
    localparam logic [1:0] WR_THROUGH = 2'b01;
    localparam logic [1:0] WR_RBW     = 2'b10;
    localparam logic [1:0] WR_ILLEGAL = 2'b11;

    // Widest word the shared merge helper handles; instances are zero-extended into it.
    localparam int MAX_DW    = 144;
    localparam int MAX_BYTES = 18;

    // Bit i of the result comes from di_w when its byte lane (i / bw) is enabled,
    // otherwise from old_w. bw is a per-instance constant, so this folds to muxes.
    function automatic logic [MAX_DW-1:0] lane_merge(
        input logic [MAX_DW-1:0]    old_w,
        input logic [MAX_DW-1:0]    di_w,
        input logic [MAX_BYTES-1:0] be,
        input int                   bw
    );
        logic [MAX_DW-1:0] res;
        logic [4:0]        lane;
        res = old_w;
        for (int i = 0; i < MAX_DW; i++) begin
            lane = 5'(i / bw);
            if (be[lane]) begin
                res[i] = di_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bsram_out_reg.sv
// rtl/bsram_out_reg.sv - pipeline output register with reset over output-enable priority
// Ports:
//   clk_i   - clock, rising edge
//   reset_i - synchronous active-high clear
//   oce_i   - load enable
//   d_i     - data in
//   q_o     - registered data out
module bsram_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  oce_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else if (oce_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bsram_sp_param.sv
// rtl/bsram_sp_param.sv - parametrised single-port block SRAM with byte enables and optional output pipeline
// Ports:
//   CLK    - clock, rising edge
//   RESET  - synchronous active-high; clears output registers only, never the array
//   CE     - array access enable
//   OCE    - output register enable (pipeline read mode only)
//   WRE    - 1 write, 0 read
//   BLKSEL - block select, compared against BLK_SEL
//   AD     - word address
//   BE     - byte write enables, one per BYTE_WIDTH lane of DI
//   DI     - write data
//   DO     - read data
module bsram_sp_param
    import bsram_pkg::*;
#(
    parameter int              DATA_WIDTH = 16,
    parameter int              BYTE_WIDTH = 8,
    parameter int              ADDR_WIDTH = 10,
    parameter logic            READ_MODE  = 1'b0,
    parameter logic [1:0]      WRITE_MODE = 2'b00,
    parameter logic [2:0]      BLK_SEL    = 3'b000,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           CE,
    input  logic                           OCE,
    input  logic                           WRE,
    input  logic [2:0]                     BLKSEL,
    input  logic [ADDR_WIDTH-1:0]          AD,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] BE,
    input  logic [DATA_WIDTH-1:0]          DI,
    output logic [DATA_WIDTH-1:0]          DO
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_dw
        $fatal(1, "bsram_sp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (BYTE_WIDTH != 8 && BYTE_WIDTH != 9) begin : g_chk_bw
        $fatal(1, "bsram_sp_param: BYTE_WIDTH must be 8 or 9");
    end
    if (WRITE_MODE == WR_ILLEGAL) begin : g_chk_wm
        $fatal(1, "bsram_sp_param: WRITE_MODE 2'b11 is illegal");
    end
    if (DATA_WIDTH > MAX_DW || NUM_BYTES > MAX_BYTES) begin : g_chk_max
        $fatal(1, "bsram_sp_param: DATA_WIDTH exceeds lane_merge capacity");
    end

    // Array is preloaded so reads before any write never return X.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_VALUE};

    logic                  acc;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] dl_q;
    logic [DATA_WIDTH-1:0] dl_d;

    assign acc     = CE & (BLKSEL == BLK_SEL);
    assign rd_word = mem_q[AD];

    always_comb begin
        merged = DATA_WIDTH'(lane_merge(MAX_DW'(rd_word), MAX_DW'(DI),
                                        MAX_BYTES'(BE), BYTE_WIDTH));
    end

    // Array writes ignore RESET on purpose: reset only clears the read path.
    always_ff @(posedge CLK) begin
        if (acc && WRE) begin
            mem_q[AD] <= merged;
        end
    end

    // rd_word is sampled before the write lands, giving read-before-write for free.
    always_comb begin
        dl_d = dl_q;
        if (acc) begin
            if (!WRE) begin
                dl_d = rd_word;
            end else begin
                case (WRITE_MODE)
                    WR_THROUGH: dl_d = merged;
                    WR_RBW:     dl_d = rd_word;
                    default:    dl_d = dl_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dl_q <= '0;
        end else begin
            dl_q <= dl_d;
        end
    end

    if (READ_MODE == READ_PIPELINE) begin : g_pipe
        logic [DATA_WIDTH-1:0] pr;
        bsram_out_reg #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_out_reg (
            .clk_i   (CLK),
            .reset_i (RESET),
            .oce_i   (OCE),
            .d_i     (dl_q),
            .q_o     (pr)
        );
        assign DO = pr;
    end else begin : g_bypass
        logic unused_oce;
        assign unused_oce = OCE;
        assign DO = dl_q;
    end

    always @(posedge CLK) begin
        assert (!$isunknown({CE, WRE, BLKSEL, RESET}))
        else $error("bsram_sp_param: X/Z on CE, WRE, BLKSEL or RESET at clock edge");
    end

endmodule

// File: tb/tb_bsram_sp_param.sv
// tb/tb_bsram_sp_param.sv - self-checking bench for bsram_sp_param across read/write modes
module tb_bsram_sp_param;

    localparam int         AW = 4;
    localparam int         NI = 3;
    localparam logic [15:0] INIT = 16'hA5A5;

    // Instance geometry: 0 bypass/RBW, 1 pipeline/write-through, 2 bypass/normal on block 2.
    localparam logic       RM [NI] = '{1'b0, 1'b1, 1'b0};
    localparam logic [1:0] WM [NI] = '{2'b10, 2'b01, 2'b00};
    localparam logic [2:0] BS [NI] = '{3'b000, 3'b000, 3'b010};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ce = 1'b0;
    logic          oce = 1'b0;
    logic          wre = 1'b0;
    logic [2:0]    blksel = 3'b000;
    logic [AW-1:0] ad = '0;
    logic [1:0]    be = 2'b00;
    logic [15:0]   di = '0;
    logic [15:0]   dout [NI];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_mem [NI][2**AW];
    logic [15:0] m_dl  [NI];
    logic [15:0] m_pr  [NI];

    always #5 clk = ~clk;

    bsram_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .READ_MODE(RM[0]),
                     .WRITE_MODE(WM[0]), .BLK_SEL(BS[0]), .INIT_VALUE(INIT)) u0 (
        .CLK(clk), .RESET(reset), .CE(ce), .OCE(oce), .WRE(wre), .BLKSEL(blksel),
        .AD(ad), .BE(be), .DI(di), .DO(dout[0]));
    bsram_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .READ_MODE(RM[1]),
                     .WRITE_MODE(WM[1]), .BLK_SEL(BS[1]), .INIT_VALUE(INIT)) u1 (
        .CLK(clk), .RESET(reset), .CE(ce), .OCE(oce), .WRE(wre), .BLKSEL(blksel),
        .AD(ad), .BE(be), .DI(di), .DO(dout[1]));
    bsram_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .READ_MODE(RM[2]),
                     .WRITE_MODE(WM[2]), .BLK_SEL(BS[2]), .INIT_VALUE(INIT)) u2 (
        .CLK(clk), .RESET(reset), .CE(ce), .OCE(oce), .WRE(wre), .BLKSEL(blksel),
        .AD(ad), .BE(be), .DI(di), .DO(dout[2]));

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_do(input int k);
        return RM[k] ? m_pr[k] : m_dl[k];
    endfunction

    // Reference: what one clock edge does to each instance, from the behavioural rules.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            bit          hit;
            logic [15:0] old_w;
            logic [15:0] new_w;
            logic [15:0] prev_dl;
            hit     = ce && (blksel == BS[k]);
            old_w   = m_mem[k][ad];
            new_w   = old_w;
            prev_dl = m_dl[k];
            for (int l = 0; l < 2; l++)
                if (be[l]) new_w[l*8 +: 8] = di[l*8 +: 8];
            if (hit && wre) m_mem[k][ad] = new_w;
            if (reset)                         m_dl[k] = 16'h0;
            else if (hit && !wre)              m_dl[k] = old_w;
            else if (hit && WM[k] == 2'b01)    m_dl[k] = new_w;
            else if (hit && WM[k] == 2'b10)    m_dl[k] = old_w;
            if (reset)    m_pr[k] = 16'h0;
            else if (oce) m_pr[k] = prev_dl;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic c, input logic o,
                        input logic w, input logic [2:0] bs, input logic [AW-1:0] a,
                        input logic [1:0] b, input logic [15:0] d);
        reset = r; ce = c; oce = o; wre = w; blksel = bs; ad = a; be = b; di = d;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("%s_u%0d", tag, k), dout[k], model_do(k));
    endtask

    initial begin
        logic [15:0] held;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 2**AW; a++) m_mem[k][a] = INIT;
            m_dl[k] = 16'h0;
            m_pr[k] = 16'h0;
        end
        @(negedge clk);

        // Reset and init value
        for (int i = 0; i < 3; i++) step("rst", 1, 0, 1, 0, 3'd0, 4'd0, 2'b00, 16'h0);
        check_eq("rst_do_bypass", dout[0], 16'h0000);
        check_eq("rst_do_pipe", dout[1], 16'h0000);
        step("rd5", 0, 1, 1, 0, 3'd0, 4'd5, 2'b00, 16'h0);
        check_eq("init_bypass", dout[0], INIT);
        step("rd5w", 0, 0, 1, 0, 3'd0, 4'd0, 2'b00, 16'h0);
        check_eq("init_pipe", dout[1], INIT);

        // Byte enables
        step("be_w1", 0, 1, 1, 1, 3'd0, 4'd3, 2'b11, 16'h1234);
        step("be_w2", 0, 1, 1, 1, 3'd0, 4'd3, 2'b10, 16'hFF00);
        step("be_rd", 0, 1, 1, 0, 3'd0, 4'd3, 2'b00, 16'h0);
        check_eq("be_merge", dout[0], 16'hFF34);
        step("be_w0", 0, 1, 1, 1, 3'd0, 4'd3, 2'b00, 16'hAAAA);
        step("be_rd2", 0, 1, 1, 0, 3'd0, 4'd3, 2'b00, 16'h0);
        check_eq("be_none", dout[0], 16'hFF34);

        // Write modes
        step("wm_pre", 0, 1, 1, 1, 3'd0, 4'd7, 2'b11, 16'h1111);
        step("wm_w", 0, 1, 1, 1, 3'd0, 4'd7, 2'b11, 16'h2222);
        check_eq("wm_rbw", dout[0], 16'h1111);
        step("wm_idle", 0, 0, 1, 0, 3'd0, 4'd0, 2'b00, 16'h0);
        check_eq("wm_through", dout[1], 16'h2222);
        step("wm_n_rd", 0, 1, 1, 0, 3'd2, 4'd3, 2'b00, 16'h0);
        check_eq("wm_n_init", dout[2], INIT);
        step("wm_n_w", 0, 1, 1, 1, 3'd2, 4'd7, 2'b11, 16'h2222);
        check_eq("wm_normal_hold", dout[2], INIT);
        step("wm_n_rd2", 0, 1, 1, 0, 3'd2, 4'd7, 2'b00, 16'h0);
        check_eq("wm_normal_wrote", dout[2], 16'h2222);

        // Pipeline output enable
        step("oce_w", 0, 1, 1, 1, 3'd0, 4'd1, 2'b11, 16'hBEEF);
        held = dout[1];
        step("oce_rd", 0, 1, 0, 0, 3'd0, 4'd1, 2'b00, 16'h0);
        step("oce_h", 0, 0, 0, 0, 3'd0, 4'd0, 2'b00, 16'h0);
        check_eq("oce_held", dout[1], held);
        step("oce_go", 0, 0, 1, 0, 3'd0, 4'd0, 2'b00, 16'h0);
        check_eq("oce_load", dout[1], 16'hBEEF);

        // Block select / CE
        held = dout[2];
        step("bs_w", 0, 1, 1, 1, 3'd0, 4'd0, 2'b11, 16'hDEAD);
        check_eq("bs_hold", dout[2], held);
        step("bs_rd", 0, 1, 1, 0, 3'd2, 4'd0, 2'b00, 16'h0);
        check_eq("bs_array", dout[2], INIT);
        step("ce0_w", 0, 0, 1, 1, 3'd2, 4'd0, 2'b11, 16'h5555);
        step("ce0_rd", 0, 1, 1, 0, 3'd2, 4'd0, 2'b00, 16'h0);
        check_eq("ce0_array", dout[2], INIT);

        // Reset mid-stream
        step("mr_rd", 1, 1, 1, 0, 3'd0, 4'd3, 2'b00, 16'h0);
        check_eq("mr_rd_bypass", dout[0], 16'h0000);
        check_eq("mr_rd_pipe", dout[1], 16'h0000);
        step("mr_w", 1, 1, 1, 1, 3'd0, 4'd9, 2'b11, 16'hCAFE);
        step("mr_chk", 0, 1, 1, 0, 3'd0, 4'd9, 2'b00, 16'h0);
        check_eq("mr_write_landed", dout[0], 16'hCAFE);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [2:0] bsr;
            case ($urandom_range(0, 3))
                0, 2:    bsr = 3'd0;
                1:       bsr = 3'd2;
                default: bsr = 3'($urandom_range(0, 7));
            endcase
            step("rnd", ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 bsr, AW'($urandom), 2'($urandom), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
